// File: rtl/arp_frame_writer.sv
// ARP frame writer: serialises an Ethernet II + ARP reply/request frame into
// the TX dual-port RAM (port B). It writes one byte per write strobe, with
// optional idle cycles between strobes and optional zero padding to 60 bytes.
module arp_frame_writer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WR_WAIT   = 1,
  parameter int unsigned PAD_EN    = 1
) (
  input  logic              iDm9000aClk,
  input  logic              iRst,
  input  logic              iRunStart,
  input  logic              iMode,
  input  logic [47:0]       iLocalMac,
  input  logic [31:0]       iLocalIp,
  input  logic [47:0]       iPeerMac,
  input  logic [31:0]       iPeerIp,
  output logic              wren_b,
  output logic [ADDR_W-1:0] address_b,
  output logic [7:0]        data_b,
  output logic              oBusy,
  output logic              oRunEnd,
  output logic [6:0]        oFrameLen
);

  localparam int unsigned FrameLen = (PAD_EN != 0) ? 60 : 42;
  localparam int unsigned GapW     = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [5:0]        LastCnt  = 6'(FrameLen - 1);
  localparam logic [GapW-1:0]   LastGap  = GapW'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWrite, StGap, StDone} state_e;

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [GapW-1:0] gap_q;
  logic            mode_q;
  logic [47:0]     lmac_q, pmac_q;
  logic [31:0]     lip_q, pip_q;

  logic [5:0]        cnt_nxt;
  logic [7:0]        byte_nxt;
  logic [7:0]        byte_first;
  logic [ADDR_W-1:0] addr_nxt;
  logic              advance;
  logic              last_byte;

  // Byte idx of the frame; anything past the 42-byte ARP payload is padding.
  function automatic logic [7:0] frame_byte(input logic        mode,
                                            input logic [47:0] lmac,
                                            input logic [31:0] lip,
                                            input logic [47:0] pmac,
                                            input logic [31:0] pip,
                                            input logic [5:0]  idx);
    logic [335:0] hdr;
    hdr = {(mode ? 48'hFFFF_FFFF_FFFF : pmac), lmac, 16'h0806,
           16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, (mode ? 8'h01 : 8'h02),
           lmac, lip, (mode ? 48'h0 : pmac), pip};
    if (idx > 6'd41) return 8'h00;
    return hdr[8*(41-int'(idx)) +: 8];
  endfunction

  // Next-byte data/address; byte 0 comes from the live inputs on the start edge.
  always_comb begin
    cnt_nxt    = cnt_q + 6'd1;
    byte_nxt   = frame_byte(mode_q, lmac_q, lip_q, pmac_q, pip_q, cnt_nxt);
    byte_first = frame_byte(iMode, iLocalMac, iLocalIp, iPeerMac, iPeerIp, 6'd0);
    addr_nxt   = BaseAddr + ADDR_W'(cnt_nxt);
    last_byte  = (cnt_q == LastCnt);
    advance    = ((state_q == StWrite) && (WR_WAIT == 0)) ||
                 ((state_q == StGap) && (gap_q == LastGap));
  end

  // Frame sequencer with registered RAM-side outputs.
  always_ff @(posedge iDm9000aClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gap_q     <= '0;
      mode_q    <= 1'b0;
      lmac_q    <= '0;
      lip_q     <= '0;
      pmac_q    <= '0;
      pip_q     <= '0;
      wren_b    <= 1'b0;
      address_b <= '0;
      data_b    <= '0;
      oBusy     <= 1'b0;
      oRunEnd   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          oRunEnd <= 1'b0;
          if (iRunStart) begin
            mode_q    <= iMode;
            lmac_q    <= iLocalMac;
            lip_q     <= iLocalIp;
            pmac_q    <= iPeerMac;
            pip_q     <= iPeerIp;
            cnt_q     <= '0;
            gap_q     <= '0;
            state_q   <= StWrite;
            wren_b    <= 1'b1;
            address_b <= BaseAddr;
            data_b    <= byte_first;
            oBusy     <= 1'b1;
          end
        end
        StWrite, StGap: begin
          if (advance) begin
            if (last_byte) begin
              state_q   <= StDone;
              wren_b    <= 1'b0;
              address_b <= '0;
              oBusy     <= 1'b0;
              oRunEnd   <= 1'b1;
            end else begin
              state_q   <= StWrite;
              cnt_q     <= cnt_nxt;
              wren_b    <= 1'b1;
              address_b <= addr_nxt;
              data_b    <= byte_nxt;
            end
          end else if (state_q == StWrite) begin
            // Address and data hold through the gap; only the strobe drops.
            state_q <= StGap;
            wren_b  <= 1'b0;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StDone: begin
          oRunEnd <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oFrameLen = 7'(FrameLen);

endmodule
